// File: rtl/mitigation_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mitigation_scheduler                                                     |
// | Arbitrates fan/valve/pump actuators under a shared concurrency budget,   |
// | enforcing a minimum on-time and a cooldown per channel.                  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mitigation_scheduler #(
  parameter int MIN_ON     = 8,
  parameter int COOLDOWN   = 4,
  parameter int MAX_ACTIVE = 2,
  parameter int TIMER_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       crisis,
  input  logic [2:0] req,
  output logic [2:0] act,
  output logic [2:0] waiting,
  output logic [1:0] active_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] ON_LAST      = TIMER_W'(MIN_ON - 1);
  localparam logic [TIMER_W-1:0] COOL_LAST    = TIMER_W'(COOLDOWN - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [1:0]         LIMIT_NORMAL = 2'(MAX_ACTIVE);

  state_t             state_q [3];
  state_t             state_d [3];
  logic [TIMER_W-1:0] timer_q [3];
  logic [TIMER_W-1:0] timer_d [3];

  logic [2:0] act_q, act_d;
  logic [2:0] waiting_q, waiting_d;
  logic [1:0] active_cnt_q, active_cnt_d;

  logic [2:0] leave_on;
  logic [2:0] cand;
  logic [2:0] grant;
  logic [1:0] limit;
  logic [1:0] staying;
  logic [1:0] slots;
  logic [1:0] slots_left;

  // Arbitration: slots freed by channels leaving ON are reusable this cycle.
  always_comb begin
    limit   = crisis ? 2'd3 : LIMIT_NORMAL;
    staying = 2'd0;
    for (int i = 0; i < 3; i++) begin
      leave_on[i] = (state_q[i] == ST_ON) &&
                    (!enable || (!req[i] && (timer_q[i] >= ON_LAST)));
      cand[i]     = (state_q[i] == ST_IDLE) && req[i] && enable;
      if ((state_q[i] == ST_ON) && !leave_on[i]) begin
        staying = staying + 2'd1;
      end
    end
    slots      = (limit > staying) ? (limit - staying) : 2'd0;
    slots_left = slots;
    grant      = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (cand[i] && (slots_left != 2'd0)) begin
        grant[i]   = 1'b1;
        slots_left = slots_left - 2'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: if (grant[i])                  state_d[i] = ST_ON;
        ST_ON:   if (leave_on[i])               state_d[i] = ST_COOL;
        ST_COOL: if (timer_q[i] == COOL_LAST)   state_d[i] = ST_IDLE;
        default:                                state_d[i] = ST_IDLE;
      endcase
      // Timer restarts on every state entry and saturates otherwise.
      if (state_d[i] != state_q[i]) begin
        timer_d[i] = '0;
      end else if (&timer_q[i]) begin
        timer_d[i] = timer_q[i];
      end else begin
        timer_d[i] = timer_q[i] + TIMER_ONE;
      end
      act_d[i] = (state_d[i] == ST_ON);
    end
    waiting_d    = cand & ~grant;
    active_cnt_d = {1'b0, act_d[0]} + {1'b0, act_d[1]} + {1'b0, act_d[2]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
      act_q        <= 3'b000;
      waiting_q    <= 3'b000;
      active_cnt_q <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      act_q        <= act_d;
      waiting_q    <= waiting_d;
      active_cnt_q <= active_cnt_d;
    end
  end

  assign act        = act_q;
  assign waiting    = waiting_q;
  assign active_cnt = active_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mitigation_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mitigation_scheduler                                                  |
// | Directed and random stimulus on two instances (MAX_ACTIVE 2 and 1).      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mitigation_scheduler;

  localparam int MIN_ON   = 8;
  localparam int COOLDOWN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       crisis;
  logic [2:0] req;
  logic [2:0] act0, wait0, act1, wait1;
  logic [1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  mitigation_scheduler #(.MIN_ON(MIN_ON), .COOLDOWN(COOLDOWN), .MAX_ACTIVE(2), .TIMER_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .crisis(crisis), .req(req),
    .act(act0), .waiting(wait0), .active_cnt(cnt0)
  );

  mitigation_scheduler #(.MIN_ON(MIN_ON), .COOLDOWN(COOLDOWN), .MAX_ACTIVE(1), .TIMER_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .crisis(crisis), .req(req),
    .act(act1), .waiting(wait1), .active_cnt(cnt1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per channel, "on" with an age count, or a remaining cooldown count.
  bit       on    [2][3];
  int       age   [2][3];
  int       cool  [2][3];
  bit [2:0] m_act [2];
  bit [2:0] m_wait[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        on[m][i] = 0; age[m][i] = 0; cool[m][i] = 0;
      end
      m_act[m] = 3'b000; m_wait[m] = 3'b000;
    end
  endtask

  task automatic model_edge();
    int limit, staying, slots;
    bit [2:0] leave, cand, grant;
    for (int m = 0; m < 2; m++) begin
      limit   = crisis ? 3 : ((m == 0) ? 2 : 1);
      staying = 0;
      for (int i = 0; i < 3; i++) begin
        leave[i] = on[m][i] && (!enable || (!req[i] && age[m][i] >= MIN_ON - 1));
        cand[i]  = !on[m][i] && cool[m][i] == 0 && req[i] && enable;
        if (on[m][i] && !leave[i]) staying++;
      end
      slots = (limit > staying) ? limit - staying : 0;
      grant = 3'b000;
      for (int i = 2; i >= 0; i--) begin
        if (cand[i] && slots > 0) begin
          grant[i] = 1'b1;
          slots--;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (leave[i]) begin
          on[m][i] = 0; cool[m][i] = COOLDOWN;
        end else if (on[m][i]) begin
          age[m][i]++;
        end else if (cool[m][i] > 0) begin
          cool[m][i]--;
        end else if (grant[i]) begin
          on[m][i] = 1; age[m][i] = 0;
        end
        m_act[m][i] = on[m][i];
      end
      m_wait[m] = cand & ~grant;
    end
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".act2"},  act0,         m_act[0]);
    check({tag, ".wait2"}, wait0,        m_wait[0]);
    check({tag, ".cnt2"},  {1'b0, cnt0}, 3'($countones(m_act[0])));
    check({tag, ".act1"},  act1,         m_act[1]);
    check({tag, ".wait1"}, wait1,        m_wait[1]);
    check({tag, ".cnt1"},  {1'b0, cnt1}, 3'($countones(m_act[1])));
  endtask

  task automatic step(input string tag, input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!reset) model_edge();
      #1;
      check_all(tag);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; crisis = 1'b0; req = 3'b000;
    model_reset();
    step("reset", 2);
    check("reset_act_const", act0, 3'b000);
    @(negedge clk) reset = 1'b0;
    step("idle", 2);

    // Minimum on-time from a one-cycle pulse, then earliest re-grant with req held.
    enable = 1'b1; req = 3'b001;
    step("pulse");
    req = 3'b000;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!act0[0]) break;
      n++;
      step("minon");
    end
    check("minon_cycles", 3'(n), 3'(MIN_ON));
    req = 3'b001;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (act0[0]) break;
      step("cool");
      n++;
    end
    check("regrant_edges", 3'(n), 3'(COOLDOWN + 1));
    req = 3'b000;
    step("drain", 16);

    // Budget and priority, then same-edge slot reuse.
    req = 3'b111;
    step("budget");
    check("budget_act",  act0,         3'b110);
    check("budget_wait", wait0,        3'b001);
    check("budget_cnt",  {1'b0, cnt0}, 3'd2);
    step("budget_hold", 7);
    req = 3'b011;
    step("swap");
    check("swap_act",  act0,  3'b011);
    check("swap_wait", wait0, 3'b000);
    req = 3'b000;
    step("drain", 20);

    // Crisis raises the limit; dropping it never preempts.
    crisis = 1'b1; req = 3'b111;
    step("crisis");
    check("crisis_act", act0,         3'b111);
    check("crisis_cnt", {1'b0, cnt0}, 3'd3);
    crisis = 1'b0;
    step("crisis_drop", 8);
    check("crisis_hold", act0, 3'b111);
    req = 3'b101;
    step("crisis_rel");
    check("crisis_rel_act", act0, 3'b101);
    step("crisis_rel2", 2);
    check("crisis_nogrant", act0, 3'b101);
    req = 3'b000;
    step("drain", 20);

    // Enable drop forces off, then full cooldown before re-grant.
    req = 3'b101;
    step("en_on", 4);
    enable = 1'b0;
    step("en_drop");
    check("en_drop_act", act0, 3'b000);
    enable = 1'b1;
    for (int k = 0; k < COOLDOWN; k++) begin
      step("en_cool");
      check("en_cool_act", act0, 3'b000);
    end
    step("en_regrant");
    check("en_regrant_act", act0, 3'b101);
    req = 3'b000;
    step("drain", 20);

    // Single-slot contention on the MAX_ACTIVE=1 instance.
    req = 3'b011;
    step("one");
    check("one_act",  act1,  3'b010);
    check("one_wait", wait1, 3'b001);
    step("one_hold", 2);
    req = 3'b111;
    step("one_noprempt");
    check("one_np_act",  act1,  3'b010);
    check("one_np_wait", wait1, 3'b101);
    req = 3'b000;
    step("drain", 20);

    // Asynchronous reset in the middle of an ON period.
    req = 3'b100;
    step("pre_rst", 4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_act",  act0,         3'b000);
    check("arst_wait", wait0,        3'b000);
    check("arst_cnt",  {1'b0, cnt0}, 3'd0);
    check("arst_act1", act1,         3'b000);
    @(negedge clk);
    reset = 1'b0; req = 3'b100;
    step("post_rst");
    check("post_rst_act", act0, 3'b100);
    req = 3'b000;
    step("drain", 20);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      req    = 3'($urandom);
      enable = ($urandom_range(0, 11) != 0);
      crisis = ($urandom_range(0, 5) == 0);
      step("rand", int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mitigation_scheduler.md
# mitigation_scheduler

Sequences the three mitigation actuators of the vital-sign monitor: Micro_Fan (ch0), Selenoid_Valve (ch1) and Infuse_Pump (ch2). It sits between the vital-sign FSM's mitigation request outputs and the actuator drivers. It enforces a shared power budget, a minimum on-time and a cooldown per actuator. It grants requests in fixed priority: pump, then valve, then fan.

## Interface
- MIN_ON, 8: minimum cycles an actuator stays on once granted. Must be ≥1.
- COOLDOWN, 4: cycles an actuator is blocked after release. Must be ≥1.
- MAX_ACTIVE, 2: concurrent actuator limit in non-crisis operation. Range 1..3.
- TIMER_W, 8: per-channel timer width. Must hold max(MIN_ON, COOLDOWN).

- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high.
- enable, input, 1: alarm active, i.e. the FSM is in Peringatan or Krisis; 0 means normal.
- crisis, input, 1: total crisis; raises the concurrency limit to 3.
- req, input, 3: mitigation requests, one bit per channel as indexed in the summary.
- act, output, 3: actuator drive, 1 = ON. Registered.
- waiting, output, 3: channel is eligible and requesting but was not granted this evaluation. Registered.
- active_cnt, output, 2: popcount of act. Registered.

## Operation
- Each channel has its own state machine with states IDLE, ON and COOL, plus a TIMER_W-bit timer.
  - The timer clears to 0 on every state entry.
  - It increments each cycle and saturates at all-ones.
- act[i] = (state_i == ON).
- Per-channel transitions, evaluated on registered state each cycle:
  - IDLE → ON: when granted.
  - ON → COOL (forced): when enable = 0, regardless of the timer.
  - ON → COOL (normal): when req[i] = 0 and timer ≥ MIN_ON−1.
  - ON otherwise: stays ON. A req drop before the minimum is ignored.
  - COOL → IDLE: when timer == COOLDOWN−1. Requests are ignored during COOL.
- Arbitration, combinational on current state, result registered at the next edge:
  - limit = crisis ? 3 : MAX_ACTIVE.
  - staying = number of channels in ON that do not transition out of ON this cycle.
  - slots = limit − staying, floored at 0.
  - candidates = IDLE & req & {3{enable}}.
  - Grant candidates in order ch2, ch1, ch0 until slots are exhausted.
  - waiting[i] = candidate[i] and not granted.
- No preemption. Lowering the limit, by crisis falling or otherwise, never forces an ON channel off. New grants are withheld until staying < limit.
- A slot freed by a channel leaving ON is reusable in the same evaluation, so one actuator turns off and another turns on at the same edge.
- enable = 0 blocks all new grants and clears waiting.

## Timing
- Reset value of every output is 0, and every channel is IDLE with timer 0.
  - Reset takes effect asynchronously, including mid-ON or mid-COOL.
  - After reset deasserts, operation resumes from IDLE at the first edge.
- Grant latency: req sampled high at edge k in IDLE with a slot free → act high after edge k.
- Minimum on-time:
  - A single-cycle req pulse yields act high for exactly MIN_ON cycles.
  - A held req extends ON indefinitely.
  - Release occurs at the first edge where req = 0 and MIN_ON cycles have elapsed.
- Cooldown: act stays low for at least COOLDOWN cycles after release.
  - With req held throughout, the earliest re-grant gives act high COOLDOWN+1 edges after the falling edge of act. That is COOLDOWN cycles in COOL, then one IDLE evaluation cycle.
- enable falling: every ON channel has act low after the next edge, then performs a full cooldown.
- Simultaneous events: if enable falls in the same cycle as a grant would occur, no grant is issued (enable wins).
- waiting and active_cnt update on the same edge as act.

## Test plan
- Reset mid-operation: with ch2 ON at timer 3, assert reset asynchronously → act = 000, waiting = 000 and active_cnt = 0 immediately, without a clock edge. After release, req = 100 → act = 100 one edge later.
- Minimum on-time and cooldown (defaults): 1-cycle req[0] pulse → act[0] high for exactly 8 cycles, then low. req[0] held from the fall onward → act[0] high again 5 edges after the fall.
- Budget and priority (MAX_ACTIVE = 2, crisis = 0, enable = 1, req = 111): act = 110, waiting = 001, active_cnt = 2.
  - Then drop req[2] after 8 ON cycles → at the same edge act = 011 and waiting = 000.
- Crisis limit: req = 111 with crisis = 1 → act = 111 and active_cnt = 3.
  - Then drop crisis with req held → act stays 111 with no release.
  - Then drop req[1] after the minimum → act = 101 and no new grant, since staying = 2 equals the limit.
- Enable drop: ch0 and ch2 ON for 3 cycles with req held, then enable = 0 → act = 000 after one edge.
  - Re-raising enable during cooldown gives no grant until the 4 cooldown cycles complete.
- Priority under contention (MAX_ACTIVE = 1): req = 011 → act = 010, waiting = 001.
  - Then req[2] rises while ch1 is ON → ch2 waits; no preemption of ch1.
